// File: rtl/ram_4002.sv
// 4002 RAM/output-port chip model: 4x(16 main + 4 status) nibbles plus a 4-bit port.
// Runs on eclk only; the 4004 phase clocks are sampled, and clk2 rising edges form the bus strobe.
module ram_4002 #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       eclk,
  input  logic       ereset,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       reset,
  input  logic       cm_ram,
  input  logic [3:0] db_in,
  output logic [3:0] db_ram,
  output logic       db_ram_t,
  output logic [3:0] port_o
);

  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic       clk2_d;
  logic       stb;
  logic [2:0] ph;
  logic       sel;
  logic       src_pend;
  logic       io_valid;
  logic [1:0] rreg;
  logic [3:0] rchar;
  logic [3:0] opa;
  logic [3:0] main_mem [0:3][0:15];
  logic [3:0] stat_mem [0:3][0:3];
  logic       is_rd;
  logic       drive;
  logic [3:0] rd_data;
  logic       unused_clk1;

  assign unused_clk1 = clk1;

  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) clk2_d <= 1'b0;
    else         clk2_d <= clk2;
  end

  assign stb = clk2 & ~clk2_d;

  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      ph       <= '0;
      sel      <= 1'b0;
      src_pend <= 1'b0;
      io_valid <= 1'b0;
      rreg     <= '0;
      rchar    <= '0;
      opa      <= '0;
      port_o   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 16; j++) main_mem[i][j] <= '0;
        for (int unsigned j = 0; j < 4; j++)  stat_mem[i][j] <= '0;
      end
    end else if (stb) begin
      ph <= sync ? 3'd0 : ph + 3'd1;
      if (reset) begin
        sel      <= 1'b0;
        src_pend <= 1'b0;
        io_valid <= 1'b0;
        rreg     <= '0;
        rchar    <= '0;
        opa      <= '0;
        port_o   <= '0;
        for (int unsigned i = 0; i < 4; i++) begin
          for (int unsigned j = 0; j < 16; j++) main_mem[i][j] <= '0;
          for (int unsigned j = 0; j < 4; j++)  stat_mem[i][j] <= '0;
        end
      end else begin
        if (ph == PH_X2 && cm_ram) begin
          sel      <= (db_in[3:2] == CHIP_ID);
          src_pend <= 1'b1;
          if (db_in[3:2] == CHIP_ID) rreg <= db_in[1:0];
        end
        if (ph == PH_X3 && src_pend) begin
          if (sel) rchar <= db_in;
          src_pend <= 1'b0;
        end
        if (ph == PH_M2) begin
          io_valid <= cm_ram & sel;
          if (cm_ram & sel) opa <= db_in;
        end
        if (ph == PH_X3) io_valid <= 1'b0;
        // cm_ram high at X2 is an SRC; it takes precedence and suppresses the write
        if (ph == PH_X2 && io_valid && !cm_ram) begin
          case (opa)
            4'h0:                      main_mem[rreg][rchar]    <= db_in;
            4'h1:                      port_o                   <= db_in;
            4'h4, 4'h5, 4'h6, 4'h7:    stat_mem[rreg][opa[1:0]] <= db_in;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    is_rd = 1'b0;
    case (opa)
      4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: is_rd = 1'b1;
      default: is_rd = 1'b0;
    endcase
  end

  assign drive   = (ph == PH_X2) && io_valid && is_rd;
  assign rd_data = (opa[3:2] == 2'b11) ? stat_mem[rreg][opa[1:0]] : main_mem[rreg][rchar];

  // Drive is re-registered every eclk so it follows ph one eclk after each strobe
  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      db_ram_t <= 1'b0;
      db_ram   <= '0;
    end else if (stb && reset) begin
      db_ram_t <= 1'b0;
      db_ram   <= '0;
    end else begin
      db_ram_t <= drive;
      db_ram   <= drive ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_ram_4002.sv
// Directed bench for ram_4002: emulates 4004 bus cycles phase by phase and checks reads, port and resets.
module tb_ram_4002;

  logic       eclk = 1'b0;
  logic       ereset;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic       reset;
  logic       cm_ram;
  logic [3:0] db_in;
  logic [3:0] db_ram;
  logic       db_ram_t;
  logic [3:0] port_o;

  int total = 0;
  int bad   = 0;

  logic       t6;
  logic [3:0] v6;
  int         lk = 0;

  ram_4002 #(.CHIP_ID(2'd0)) dut (
    .eclk    (eclk),
    .ereset  (ereset),
    .clk1    (clk1),
    .clk2    (clk2),
    .sync    (sync),
    .reset   (reset),
    .cm_ram  (cm_ram),
    .db_in   (db_in),
    .db_ram  (db_ram),
    .db_ram_t(db_ram_t),
    .port_o  (port_o)
  );

  always #5 eclk = ~eclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One 4004 phase: present bus values, one clk2 pulse, return at a negedge with ph advanced.
  task automatic ph_step(input logic s, input logic cm, input logic [3:0] d);
    @(negedge eclk);
    sync = s; cm_ram = cm; db_in = d; clk2 = 1'b1; clk1 = 1'b0;
    @(negedge eclk);
    @(negedge eclk);
    clk2 = 1'b0; clk1 = 1'b1;
    @(negedge eclk);
    clk1 = 1'b0;
    @(negedge eclk);
  endtask

  // Full bus cycle A1..X3; samples drive while ph=6 and counts any drive seen elsewhere.
  task automatic bus_cycle(input logic cm4, input logic [3:0] d3, input logic [3:0] d4,
                           input logic cm6, input logic [3:0] d6, input logic [3:0] d7);
    logic       cm;
    logic [3:0] d;
    for (int k = 0; k < 8; k++) begin
      cm = (k == 4) ? cm4 : (k == 6) ? cm6 : 1'b0;
      d  = (k == 3) ? d3 : (k == 4) ? d4 : (k == 6) ? d6 : (k == 7) ? d7 : 4'h0;
      ph_step(k == 7, cm, d);
      if (k == 5) begin
        t6 = db_ram_t;
        v6 = db_ram;
      end else if (db_ram_t !== 1'b0 || db_ram !== 4'h0) begin
        lk++;
      end
    end
  endtask

  task automatic src(input logic [7:0] a);
    bus_cycle(1'b0, 4'h2, 4'h1, 1'b1, a[7:4], a[3:0]);
  endtask

  task automatic io(input logic [3:0] op, input logic [3:0] data);
    bus_cycle(1'b1, 4'hE, op, 1'b0, data, 4'h0);
  endtask

  task automatic test_reset();
    total++; if (db_ram_t !== 1'b0) begin bad++; $display("FAIL reset_t got=%b exp=0", db_ram_t); end
    total++; if (db_ram !== 4'h0) begin bad++; $display("FAIL reset_d got=%h exp=0", db_ram); end
    total++; if (port_o !== 4'h0) begin bad++; $display("FAIL reset_port got=%h exp=0", port_o); end
  endtask

  task automatic test_wrm_rdm();
    src(8'h15);
    io(4'h0, 4'hA);
    total++; if (t6 !== 1'b0) begin bad++; $display("FAIL wrm_nodrive got=%b exp=0", t6); end
    src(8'h15);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1) begin bad++; $display("FAIL rdm_t got=%b exp=1", t6); end
    total++; if (v6 !== 4'hA) begin bad++; $display("FAIL rdm_d got=%h exp=a", v6); end
    io(4'h8, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'hA) begin bad++; $display("FAIL sbm_read got=%b/%h exp=1/a", t6, v6); end
  endtask

  task automatic test_deselect();
    src(8'h40);
    io(4'h0, 4'h7);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b0) begin bad++; $display("FAIL desel_read_t got=%b exp=0", t6); end
    io(4'h1, 4'h3);
    total++; if (port_o !== 4'h0) begin bad++; $display("FAIL desel_port got=%h exp=0", port_o); end
    src(8'h00);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL desel_main0 got=%b/%h exp=1/0", t6, v6); end
    src(8'h15);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'hA) begin bad++; $display("FAIL desel_main15 got=%b/%h exp=1/a", t6, v6); end
  endtask

  task automatic test_status();
    src(8'h30);
    io(4'h6, 4'hC);
    io(4'hE, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'hC) begin bad++; $display("FAIL rd2 got=%b/%h exp=1/c", t6, v6); end
    io(4'hC, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL rd0 got=%b/%h exp=1/0", t6, v6); end
  endtask

  task automatic test_port();
    src(8'h00);
    io(4'h1, 4'h9);
    total++; if (port_o !== 4'h9) begin bad++; $display("FAIL wmp got=%h exp=9", port_o); end
    io(4'h2, 4'h5);
    total++; if (port_o !== 4'h9 || t6 !== 1'b0) begin bad++; $display("FAIL op2 got=%h/%b exp=9/0", port_o, t6); end
    io(4'hA, 4'h6);
    total++; if (port_o !== 4'h9 || t6 !== 1'b0) begin bad++; $display("FAIL opa got=%h/%b exp=9/0", port_o, t6); end
    io(4'h5, 4'h3);
    total++; if (t6 !== 1'b0) begin bad++; $display("FAIL wr1_nodrive got=%b exp=0", t6); end
    io(4'hD, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h3) begin bad++; $display("FAIL rd1 got=%b/%h exp=1/3", t6, v6); end
  endtask

  task automatic test_rchar15();
    src(8'h2F);
    io(4'h0, 4'hF);
    src(8'h20);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL char0 got=%b/%h exp=1/0", t6, v6); end
    src(8'h2F);
    io(4'hB, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'hF) begin bad++; $display("FAIL char15 got=%b/%h exp=1/f", t6, v6); end
  endtask

  task automatic test_sync_reset();
    reset = 1'b1;
    bus_cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    reset = 1'b0;
    total++; if (port_o !== 4'h0) begin bad++; $display("FAIL sreset_port got=%h exp=0", port_o); end
    src(8'h2F);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL sreset_main got=%b/%h exp=1/0", t6, v6); end
    src(8'h00);
    io(4'hD, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL sreset_stat got=%b/%h exp=1/0", t6, v6); end
  endtask

  task automatic test_ereset_mid();
    src(8'h15);
    io(4'h0, 4'hA);
    src(8'h15);
    for (int k = 0; k < 6; k++)
      ph_step(1'b0, k == 4, (k == 3) ? 4'hE : (k == 4) ? 4'h9 : 4'h0);
    total++; if (db_ram_t !== 1'b1 || db_ram !== 4'hA) begin bad++; $display("FAIL pre_ereset got=%b/%h exp=1/a", db_ram_t, db_ram); end
    ereset = 1'b0;
    #1;
    total++; if (db_ram_t !== 1'b0 || db_ram !== 4'h0) begin bad++; $display("FAIL ereset_drop got=%b/%h exp=0/0", db_ram_t, db_ram); end
    @(negedge eclk);
    ereset = 1'b1;
    src(8'h15);
    io(4'h9, 4'h0);
    total++; if (t6 !== 1'b1 || v6 !== 4'h0) begin bad++; $display("FAIL ereset_mem got=%b/%h exp=1/0", t6, v6); end
  endtask

  task automatic test_scoreboard();
    logic [3:0] model [0:3][0:15];
    int unsigned r, c, rr, rc;
    logic [3:0] d;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) model[i][j] = 4'h0;
    for (int i = 0; i < 24; i++) begin
      r = i % 4; c = (i * 7) % 16; d = 4'((i * 5 + 3) % 16);
      src({4'(r), 4'(c)});
      io(4'h0, d);
      model[r][c] = d;
      rr = (i * 3) % 4; rc = (i * 11) % 16;
      src({4'(rr), 4'(rc)});
      io(4'h9, 4'h0);
      total++;
      if (t6 !== 1'b1 || v6 !== model[rr][rc]) begin
        bad++; $display("FAIL sb_read[%0d] got=%b/%h exp=1/%h", i, t6, v6, model[rr][rc]);
      end
    end
    total++; if (lk !== 0) begin bad++; $display("FAIL drive_outside_x2 got=%0d exp=0", lk); end
  endtask

  initial begin
    ereset = 1'b0; clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0;
    reset = 1'b0; cm_ram = 1'b0; db_in = 4'h0;
    repeat (4) @(negedge eclk);
    ereset = 1'b1;
    test_reset();
    test_wrm_rdm();
    test_deselect();
    test_status();
    test_port();
    test_rchar15();
    test_sync_reset();
    test_ereset_mid();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
